// File: rtl/dm_bytewise_if.sv
// dm_bytewise_if: load/store bus between the datapath and dm_bytewise.
//   addr     byte address (word index in [AW-1:2], lane in [1:0])
//   din      store data (low byte/halfword used for sub-word stores)
//   DMWr     write strobe
//   mode     00 word, 01 halfword, 10 byte, 11 reserved
//   sign_ext 1 = sign-extend sub-word loads, 0 = zero-extend
//   dout     combinational load data
//   busy     high while the post-reset clear walk runs
//   misalign combinational misaligned/reserved-mode indication
//   fault    sticky misaligned-write flag
// master = datapath side, slave = memory side.
interface dm_bytewise_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           din;
  logic                  DMWr;
  logic [1:0]            mode;
  logic                  sign_ext;
  logic [31:0]           dout;
  logic                  busy;
  logic                  misalign;
  logic                  fault;

  modport master (
    output addr, din, DMWr, mode, sign_ext,
    input  dout, busy, misalign, fault
  );

  modport slave (
    input  addr, din, DMWr, mode, sign_ext,
    output dout, busy, misalign, fault
  );
endinterface

// File: rtl/dm_bytewise.sv
// dm_bytewise: byte-addressable data memory for the single-cycle MIPS datapath.
// Word/halfword/byte stores with lane enables, sign/zero-extended sub-word
// loads, misalignment detection with a sticky fault flag, and an optional
// post-reset walk that zeroes every word.
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   bus    dm_bytewise_if.slave (addr, din, DMWr, mode, sign_ext in;
//          dout, busy, misalign, fault out)
module dm_bytewise #(
  parameter int ADDR_WIDTH = 12,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_bytewise_if.slave  bus
);
  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam logic [1:0] M_WORD = 2'b00;
  localparam logic [1:0] M_HALF = 2'b01;
  localparam logic [1:0] M_BYTE = 2'b10;

  logic [0:0]    r_state;
  logic [IW-1:0] r_ptr;
  logic          r_fault;
  logic [31:0]   r_mem [DEPTH];

  logic [IW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_busy;
  logic          w_misalign;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_word;
  logic [15:0]   w_half;
  logic [7:0]    w_byte;
  logic [31:0]   w_dout;

  assign w_idx  = bus.addr[ADDR_WIDTH-1:2];
  assign w_lane = bus.addr[1:0];
  assign w_busy = (r_state == S_CLEAR);

  assign w_misalign = ((bus.mode == M_HALF) && w_lane[0]) ||
                      ((bus.mode == M_WORD) && (w_lane != 2'b00)) ||
                      (bus.mode == 2'b11);

  // Store data is replicated across lanes so each lane enable simply
  // picks its own byte from w_wdata.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.din;
    case (bus.mode)
      M_WORD: begin
        w_be    = 4'b1111;
        w_wdata = bus.din;
      end
      M_HALF: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.din[15:0]}};
      end
      M_BYTE: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{bus.din[7:0]}};
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = bus.din;
      end
    endcase
  end

  // Combinational read path: lane select then extension.
  assign w_word = r_mem[w_idx];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];

  always_comb begin
    w_dout = 32'h0;
    if (!w_busy && !w_misalign) begin
      case (bus.mode)
        M_WORD:  w_dout = w_word;
        M_HALF:  w_dout = {{16{bus.sign_ext & w_half[15]}}, w_half};
        M_BYTE:  w_dout = {{24{bus.sign_ext & w_byte[7]}}, w_byte};
        default: w_dout = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= INIT_CLEAR ? S_CLEAR : S_RUN;
      r_ptr   <= '0;
      r_fault <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      // Writes offered during the walk are dropped without raising fault.
      r_mem[r_ptr] <= 32'h0;
      r_ptr        <= r_ptr + 1'b1;
      if (r_ptr == {IW{1'b1}})
        r_state <= S_RUN;
    end else if (bus.DMWr) begin
      if (w_misalign) begin
        r_fault <= 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i])
            r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.dout     = w_dout;
  assign bus.busy     = w_busy;
  assign bus.misalign = w_misalign;
  assign bus.fault    = r_fault;
endmodule

// File: tb/tb_dm_bytewise.sv
// tb_dm_bytewise: directed and randomized checks of dm_bytewise
// (ADDR_WIDTH=6, INIT_CLEAR=1) against an arithmetic reference model.
module tb_dm_bytewise;
  localparam int AW    = 6;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;

  dm_bytewise_if #(.ADDR_WIDTH(AW)) bus ();

  dm_bytewise #(.ADDR_WIDTH(AW), .INIT_CLEAR(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  int          m_walk;
  bit          m_busy;
  bit          m_fault;

  function automatic bit m_mis(input logic [AW-1:0] a, input logic [1:0] md);
    return (md == 2'd3) || (md == 2'd1 && a[0]) || (md == 2'd0 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a, input logic [1:0] md,
                                         input logic sx);
    logic [31:0] w, v;
    if (m_busy || m_mis(a, md)) return 32'h0;
    w = m_mem[int'(a) / 4];
    if (md == 2'd0) return w;
    if (md == 2'd1) begin
      v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction

  // Apply the effect of the coming rising edge to the model.
  task automatic model_edge();
    logic [31:0] mask, val;
    int sh;
    if (!rst_n) begin
      m_walk  = 0;
      m_busy  = 1'b1;
      m_fault = 1'b0;
    end else if (m_busy) begin
      m_mem[m_walk] = 32'h0;
      m_walk++;
      if (m_walk == DEPTH) m_busy = 1'b0;
    end else if (bus.DMWr) begin
      if (m_mis(bus.addr, bus.mode)) begin
        m_fault = 1'b1;
      end else begin
        if (bus.mode == 2'd0) begin
          mask = 32'hFFFFFFFF;
          val  = bus.din;
        end else if (bus.mode == 2'd1) begin
          sh   = 16 * int'(bus.addr[1]);
          mask = 32'hFFFF << sh;
          val  = (bus.din & 32'hFFFF) << sh;
        end else begin
          sh   = 8 * int'(bus.addr[1:0]);
          mask = 32'hFF << sh;
          val  = (bus.din & 32'hFF) << sh;
        end
        m_mem[int'(bus.addr) / 4] = (m_mem[int'(bus.addr) / 4] & ~mask) | val;
      end
    end
  endtask

  task automatic edge_step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model.
  task automatic chk(input string tag);
    check_val({tag, ".dout"}, bus.dout, m_read(bus.addr, bus.mode, bus.sign_ext));
    check_val({tag, ".busy"}, {31'h0, bus.busy}, {31'h0, m_busy});
    check_val({tag, ".misalign"}, {31'h0, bus.misalign}, {31'h0, m_mis(bus.addr, bus.mode)});
    check_val({tag, ".fault"}, {31'h0, bus.fault}, {31'h0, m_fault});
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [1:0] md, input logic [31:0] d,
                       input logic wr, input logic sx);
    bus.addr     = a;
    bus.mode     = md;
    bus.din      = d;
    bus.DMWr     = wr;
    bus.sign_ext = sx;
    #1;
  endtask

  initial begin
    int n;
    n_cmp  = 0;
    n_fail = 0;
    m_busy = 1'b1;
    m_fault = 1'b0;
    m_walk = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;

    // Reset, then a clear walk with a write offered at addr 0 throughout.
    rst_n = 1'b0;
    drive(6'h00, 2'd0, 32'hDEADBEEF, 1'b1, 1'b0);
    edge_step();
    chk("reset");
    check_val("reset_busy", {31'h0, bus.busy}, 32'h1);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1 chk("walk");
      edge_step();
    end
    drive(6'h00, 2'd0, 32'h0, 1'b0, 1'b0);
    chk("after_walk");
    check_val("walk_drop_w0", bus.dout, 32'h0);
    check_val("walk_drop_fault", {31'h0, bus.fault}, 32'h0);

    // Byte store and loads
    drive(6'h05, 2'd2, 32'h123456AB, 1'b1, 1'b0); chk("sb"); edge_step();
    drive(6'h04, 2'd0, 32'h0, 1'b0, 1'b0); chk("sb_rd");
    check_val("sb_word", bus.dout, 32'h0000AB00);
    drive(6'h05, 2'd2, 32'h0, 1'b0, 1'b1); check_val("lb_sx", bus.dout, 32'hFFFFFFAB);
    drive(6'h05, 2'd2, 32'h0, 1'b0, 1'b0); check_val("lbu", bus.dout, 32'h000000AB);

    // Halfword stores and loads
    drive(6'h06, 2'd1, 32'h00008001, 1'b1, 1'b0); chk("sh_hi"); edge_step();
    drive(6'h04, 2'd1, 32'h00007FFF, 1'b1, 1'b0); chk("sh_lo"); edge_step();
    drive(6'h04, 2'd0, 32'h0, 1'b0, 1'b0); check_val("sh_word", bus.dout, 32'h80017FFF);
    drive(6'h06, 2'd1, 32'h0, 1'b0, 1'b1); check_val("lh_sx", bus.dout, 32'hFFFF8001);
    drive(6'h04, 2'd1, 32'h0, 1'b0, 1'b0); check_val("lhu", bus.dout, 32'h00007FFF);

    // Misaligned word store sets sticky fault
    drive(6'h02, 2'd0, 32'h11112222, 1'b1, 1'b0);
    check_val("sw_mis", {31'h0, bus.misalign}, 32'h1);
    edge_step();
    drive(6'h00, 2'd0, 32'h0, 1'b0, 1'b0);
    check_val("sw_mis_w0", bus.dout, 32'h0);
    check_val("sw_mis_fault", {31'h0, bus.fault}, 32'h1);
    drive(6'h08, 2'd0, 32'h55AA55AA, 1'b1, 1'b0); edge_step();
    drive(6'h08, 2'd0, 32'h0, 1'b0, 1'b0);
    check_val("good_wr", bus.dout, 32'h55AA55AA);
    check_val("fault_sticky", {31'h0, bus.fault}, 32'h1);
    drive(6'h03, 2'd1, 32'h0, 1'b0, 1'b1);
    check_val("lh_mis", {31'h0, bus.misalign}, 32'h1);
    check_val("lh_mis_dout", bus.dout, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 120; i++) begin
      drive(AW'($urandom), 2'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("rand");
      edge_step();
    end

    // Preload nonzero words, reset, confirm the walk zeroes all of them.
    for (int i = 0; i < DEPTH; i++) begin
      drive(AW'(i * 4), 2'd0, $urandom | 32'h1, 1'b1, 1'b0);
      edge_step();
    end
    drive(6'h00, 2'd0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0; edge_step(); rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_val("preload_busy", {31'h0, bus.busy}, 32'h1);
      edge_step();
    end
    check_val("preload_done", {31'h0, bus.busy}, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(AW'(i * 4), 2'd0, 32'h0, 1'b0, 1'b0);
      check_val("cleared_word", bus.dout, 32'h0);
    end

    // Reset at walk step 8 restarts a full walk
    rst_n = 1'b0; edge_step(); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) edge_step();
    rst_n = 1'b0; edge_step(); rst_n = 1'b1;
    n = 0;
    while (bus.busy && n < 40) begin
      edge_step();
      n++;
    end
    check_val("midwalk_edges", n, 32'd16);
    drive(6'h3C, 2'd0, 32'hCAFEF00D, 1'b1, 1'b0); chk("sw_3c"); edge_step();
    drive(6'h3C, 2'd0, 32'h0, 1'b0, 1'b0); chk("rd_3c");
    check_val("rd_3c_val", bus.dout, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_bytewise.md
# dm_bytewise

Parametrised data memory for the single-cycle MIPS datapath, the successor to the fixed 4 KiB word-only data memory. It adds configurable depth, byte and halfword stores with lane enables, sign- or zero-extended sub-word loads, misalignment detection with a sticky fault flag, and a post-reset hardware clear sequence. It sits between the ALU address output and the write-back mux, and is read combinationally and written on the rising clock edge.

## Interface
Parameters:
- ADDR_WIDTH, 12, byte-address width; DEPTH = 2^(ADDR_WIDTH-2) 32-bit words; legal range 4..16.
- INIT_CLEAR, 1, 1 = zero every word after reset; 0 = skip the clear walk.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- addr  in  ADDR_WIDTH  byte address; addr[ADDR_WIDTH-1:2] is the word index and addr[1:0] is the lane.
- din  in  32  store data; the low byte or halfword is used for sub-word stores.
- DMWr  in  1  write strobe.
- mode  in  2  00 word, 01 halfword, 10 byte, 11 reserved.
- sign_ext  in  1  1 = sign-extend sub-word loads; 0 = zero-extend.
- dout  out  32  load data (combinational).
- busy  out  1  high while the clear walk runs.
- misalign  out  1  combinational; current access is misaligned or uses the reserved mode.
- fault  out  1  sticky; set by a misaligned write attempt.

## Operation
- State machine: CLEAR, RUN.
- On any edge with rst_n=0:
  - state<=CLEAR, ptr<=0, fault<=0.
  - No memory write.
  - If INIT_CLEAR=0, state<=RUN instead.
- CLEAR, each edge with rst_n=1:
  - mem[ptr]<=0, ptr<=ptr+1.
  - On the edge that writes ptr=DEPTH-1, state<=RUN.
  - ptr is ADDR_WIDTH-2 bits wide and wraps to 0; the wrap is never used.
- busy = (state==CLEAR).
- While busy, dout=0 and DMWr is ignored; dropped writes do not set fault.
- misalign = (mode==01 & addr[0]) | (mode==00 & addr[1:0]!=0) | (mode==11).
- RUN write, on an edge with DMWr=1 and misalign=0:
  - word: mem[idx]<=din.
  - half: lane pair addr[1] receives din[15:0]; the other halfword is unchanged.
  - byte: lane addr[1:0] receives din[7:0]; the other bytes are unchanged.
- RUN write with DMWr=1 and misalign=1: memory is unchanged and fault<=1.
- fault clears only on reset.
- Read (RUN):
  - w = mem[idx].
  - word: dout=w.
  - half: h = w[31:16] if addr[1], else w[15:0]; extend h to 32 bits per sign_ext.
  - byte: b = w[8*addr[1:0]+7 : 8*addr[1:0]]; extend b to 32 bits per sign_ext.
  - Misaligned or reserved read: dout=0.
- Lane numbering is little-endian: lane 0 = bits 7:0.
- Reset values: busy=1 (0 when INIT_CLEAR=0 after the first reset edge), fault=0, dout=0 while busy.

## Timing
- Load latency is 0 cycles: dout follows addr, mode and sign_ext combinationally from the array.
- Store takes effect at the rising edge.
- Read of the address being written in the same cycle: dout shows the old contents until the edge and the new contents after it.
- Clear walk: busy stays high for exactly DEPTH edges after the first edge with rst_n=1. It falls after the edge that clears word DEPTH-1. The first accepted write is on the following edge.
- Reset asserted mid-walk or mid-operation: the next edge restarts CLEAR at ptr=0. A write presented on that edge is dropped. Words not yet re-walked keep their old values until cleared.
- DMWr held over several edges writes on each edge; no handshake is required beyond busy=0.

## Test plan
- ADDR_WIDTH=6, INIT_CLEAR=1, after preloading nonzero data: release rst_n -> busy high for 16 edges then low; all 16 words read 0x00000000.
- RUN, mem[1]=0; sb din=0x123456AB at addr 0x05 -> word read at 0x04 = 0x0000AB00. lb at 0x05 with sign_ext=1 -> 0xFFFFFFAB; with sign_ext=0 -> 0x000000AB.
- sh din=0x00008001 at addr 0x06, then sh din=0x7FFF at 0x04 -> word at 0x04 = 0x80017FFF. lh at 0x06 with sign_ext=1 -> 0xFFFF8001. lhu at 0x04 -> 0x00007FFF.
- sw at addr 0x02 -> misalign=1, word 0 unchanged, fault=1 and stays 1 across later good writes. lh at 0x03 -> misalign=1, dout=0.
- DMWr=1 with din=0xDEADBEEF at addr 0x00 during the clear walk -> after busy falls, word 0 = 0 and fault=0.
- rst_n low for one edge at walk step 8 -> busy high for a further 16 edges; then write and read back 0xCAFEF00D at addr 0x3C.
